// File: rtl/butterfly_pair_feeder.sv
// Pairs a serial sample stream into radix-2 butterfly legs x[n] / x[n+STRIDE].
// The later leg (out1) leaves immediately for the twiddle multiplier; the
// earlier leg (out0) is delayed ALIGN_DELAY cycles to meet it downstream.
module butterfly_pair_feeder #(
  parameter int DATA_WIDTH         = 16,
  parameter int VIRTUAL_DATA_WIDTH = 18,
  parameter int STRIDE             = 4,
  parameter int ALIGN_DELAY        = 2,
  localparam int IDX_W             = (STRIDE > 1) ? $clog2(STRIDE) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 in_valid,
  input  logic signed [DATA_WIDTH-1:0]         real_in,
  input  logic signed [DATA_WIDTH-1:0]         imag_in,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] real_out1,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] imag_out1,
  output logic                                 valid1,
  output logic        [IDX_W-1:0]              pair_index,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] real_out0,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] imag_out0,
  output logic                                 valid0
);

  localparam int CNT_W = $clog2(2 * STRIDE);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(STRIDE - 1);
  localparam logic [CNT_W-1:0] PAIR_LAST = CNT_W'(2 * STRIDE - 1);
  localparam logic [CNT_W-1:0] PAIR_BASE = CNT_W'(STRIDE);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(STRIDE - 1);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  // Widen a sample by replicating its sign bit; no rounding or saturation.
  function automatic logic signed [VIRTUAL_DATA_WIDTH-1:0] sext(
    input logic signed [DATA_WIDTH-1:0] x
  );
    return VIRTUAL_DATA_WIDTH'(x);
  endfunction

  // FIFO pointer advance with wrap at STRIDE-1 (STRIDE need not fill IDX_W).
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             accept;
  logic             fifo_wr;
  logic             pair_pop;

  logic signed [VIRTUAL_DATA_WIDTH-1:0] fifo_re [STRIDE];
  logic signed [VIRTUAL_DATA_WIDTH-1:0] fifo_im [STRIDE];

  logic signed [VIRTUAL_DATA_WIDTH-1:0] aln_re_p [ALIGN_DELAY];
  logic signed [VIRTUAL_DATA_WIDTH-1:0] aln_im_p [ALIGN_DELAY];
  logic        [ALIGN_DELAY-1:0]        aln_vld_p;

  assign accept = enable & in_valid;

  // Next-state, counter and FIFO strobes; enable=0 blocks acceptance, freezing all three.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_wr  = 1'b0;
    pair_pop = 1'b0;
    if (accept) begin
      cnt_d = (cnt_q == PAIR_LAST) ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      FILL: begin
        if (accept) begin
          fifo_wr = 1'b1;
          if (cnt_q == FILL_LAST) state_d = PAIR;
        end
      end
      PAIR: begin
        if (accept) begin
          pair_pop = 1'b1;
          if (cnt_q == PAIR_LAST) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counter and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fifo_wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pair_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // FIFO storage holds the first half of each block, already widened.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_re[wr_ptr_q] <= sext(real_in);
      fifo_im[wr_ptr_q] <= sext(imag_in);
    end
  end

  // ---- p0: later leg leaves now, earlier leg enters the alignment pipe ----
  // Later leg register; data holds while no pair is formed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1     <= 1'b0;
      real_out1  <= '0;
      imag_out1  <= '0;
      pair_index <= '0;
    end else begin
      valid1 <= pair_pop;
      if (pair_pop) begin
        real_out1  <= sext(real_in);
        imag_out1  <= sext(imag_in);
        pair_index <= IDX_W'(cnt_q - PAIR_BASE);
      end
    end
  end

  // ---- p1..pN: alignment pipe, shifts every cycle regardless of enable ----
  // Valid bubbles travel with the data so out0 timing never depends on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aln_vld_p <= '0;
      for (int j = 0; j < ALIGN_DELAY; j++) begin
        aln_re_p[j] <= '0;
        aln_im_p[j] <= '0;
      end
    end else begin
      aln_vld_p[0] <= pair_pop;
      if (pair_pop) begin
        aln_re_p[0] <= fifo_re[rd_ptr_q];
        aln_im_p[0] <= fifo_im[rd_ptr_q];
      end
      for (int j = 1; j < ALIGN_DELAY; j++) begin
        aln_vld_p[j] <= aln_vld_p[j-1];
        aln_re_p[j]  <= aln_re_p[j-1];
        aln_im_p[j]  <= aln_im_p[j-1];
      end
    end
  end

  // ---- output: earlier leg, updated only when a valid slot arrives ----
  // Earlier leg register; holds its last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0    <= 1'b0;
      real_out0 <= '0;
      imag_out0 <= '0;
    end else begin
      valid0 <= aln_vld_p[ALIGN_DELAY-1];
      if (aln_vld_p[ALIGN_DELAY-1]) begin
        real_out0 <= aln_re_p[ALIGN_DELAY-1];
        imag_out0 <= aln_im_p[ALIGN_DELAY-1];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_pair_feeder.sv
// Directed bench for butterfly_pair_feeder at default parameters
// (DATA_WIDTH=16, VIRTUAL_DATA_WIDTH=18, STRIDE=4, ALIGN_DELAY=2).
module tb_butterfly_pair_feeder;

  localparam int DW = 16;
  localparam int VW = 18;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 in_valid;
  logic signed [DW-1:0] real_in;
  logic signed [DW-1:0] imag_in;
  logic signed [VW-1:0] real_out1;
  logic signed [VW-1:0] imag_out1;
  logic                 valid1;
  logic        [IW-1:0] pair_index;
  logic signed [VW-1:0] real_out0;
  logic signed [VW-1:0] imag_out0;
  logic                 valid0;

  int    nvec = 0;
  int    nerr = 0;
  int    h_r1, h_i1, h_pi, h_r0, h_i0;
  string phase;
  int    v6 [8] = '{32767, 0, 0, 0, -32768, 0, 0, 0};
  logic [VW-1:0] raw;

  butterfly_pair_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .real_in    (real_in),
    .imag_in    (imag_in),
    .real_out1  (real_out1),
    .imag_out1  (imag_out1),
    .valid1     (valid1),
    .pair_index (pair_index),
    .real_out0  (real_out0),
    .imag_out0  (imag_out0),
    .valid0     (valid0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s %s: observed %0d required %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".valid1"},     32'(valid1),     0);
    chk({tag, ".valid0"},     32'(valid0),     0);
    chk({tag, ".real_out1"},  32'(real_out1),  0);
    chk({tag, ".imag_out1"},  32'(imag_out1),  0);
    chk({tag, ".pair_index"}, 32'(pair_index), 0);
    chk({tag, ".real_out0"},  32'(real_out0),  0);
    chk({tag, ".imag_out0"},  32'(imag_out0),  0);
  endtask

  task automatic clear_hold();
    h_r1 = 0; h_i1 = 0; h_pi = 0; h_r0 = 0; h_i0 = 0;
  endtask

  // Drive one cycle, then check every output against the expected values
  // (data outputs are expected to hold when the matching valid is low).
  task automatic step(input logic en, input logic iv, input int re, input int im,
                      input logic ev1, input int er1, input int ei1, input int epi,
                      input logic ev0, input int er0, input int ei0);
    @(negedge clk);
    enable   = en;
    in_valid = iv;
    real_in  = DW'(re);
    imag_in  = DW'(im);
    @(posedge clk);
    #1;
    if (ev1) begin h_r1 = er1; h_i1 = ei1; h_pi = epi; end
    if (ev0) begin h_r0 = er0; h_i0 = ei0; end
    chk("valid1",     32'(valid1),     32'(ev1));
    chk("real_out1",  32'(real_out1),  h_r1);
    chk("imag_out1",  32'(imag_out1),  h_i1);
    chk("pair_index", 32'(pair_index), h_pi);
    chk("valid0",     32'(valid0),     32'(ev0));
    chk("real_out0",  32'(real_out0),  h_r0);
    chk("imag_out0",  32'(imag_out0),  h_i0);
  endtask

  initial begin
    int x, p;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; real_in = '0; imag_in = '0;
    clear_hold();

    // Reset, then idle with no input.
    phase = "reset";
    @(posedge clk); #1;
    all_zero("in_rst");
    @(negedge clk); rst = 1'b0;
    phase = "idle";
    for (int t = 1; t <= 4; t++) step(1'b1, 1'b0, 7, 7, 0, 0, 0, 0, 0, 0, 0);

    // Eight contiguous samples 1..8 / -1..-8.
    phase = "contig";
    for (int t = 1; t <= 12; t++)
      step(1'b1, t <= 8, t, -t,
           t >= 5 && t <= 8, t, -t, t - 5,
           t >= 7 && t <= 10, t - 6, -(t - 6));

    // Same samples with in_valid low every other cycle.
    phase = "gapped";
    for (int t = 1; t <= 18; t++) begin
      x = (t + 1) / 2;
      p = (t - 1) / 2 - 4;
      step(1'b1, (t % 2 == 1) && t <= 15, x, -x,
           (t % 2 == 1) && t <= 15 && x >= 5, x, -x, x - 5,
           (t % 2 == 1) && t >= 11 && t <= 17, p, -p);
    end

    // enable low for three cycles right after the 5th sample.
    phase = "enable";
    for (int t = 1; t <= 14; t++) begin
      x = (t <= 5) ? t : ((t <= 8) ? 99 : t - 3);
      p = (t == 7) ? 1 : t - 9;
      step(!(t >= 6 && t <= 8), t <= 11, x, -x,
           t == 5 || (t >= 9 && t <= 11), x, -x, x - 5,
           t == 7 || (t >= 11 && t <= 13), p, -p);
    end

    // Reset after six accepted samples; pending pairs must vanish.
    phase = "midrst";
    for (int t = 1; t <= 6; t++)
      step(1'b1, 1'b1, t, -t, t >= 5, t, -t, t - 5, 0, 0, 0);
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0;
    #2;
    all_zero("async");
    clear_hold();
    repeat (2) @(posedge clk);
    #1;
    all_zero("held");
    @(negedge clk); rst = 1'b0;
    for (int t = 1; t <= 12; t++)
      step(1'b1, t <= 8, t + 9, -(t + 9),
           t >= 5 && t <= 8, t + 9, -(t + 9), t - 5,
           t >= 7 && t <= 10, t + 3, -(t + 3));

    // Extremes: most negative in the pairing leg, most positive in the FIFO leg.
    phase = "extreme";
    for (int t = 1; t <= 10; t++) begin
      x = (t <= 8) ? v6[t-1] : 0;
      p = (t >= 7) ? v6[(t >= 7) ? t - 7 : 0] : 0;
      step(1'b1, t <= 8, x, x,
           t >= 5 && t <= 8, x, x, t - 5,
           t >= 7 && t <= 10, p, p);
      if (t == 5) begin
        raw = real_out1;
        chk("re1_raw", 32'(raw), 32'h38000);
      end
      if (t == 7) begin
        raw = real_out0;
        chk("re0_raw", 32'(raw), 32'h07FFF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/butterfly_pair_feeder.md
BUTTERFLY_PAIR_FEEDER -- requirements
Module: butterfly_pair_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the incoming signed sample components.
REQ-002 SHALL have parameter VIRTUAL_DATA_WIDTH, default 18, width of the signed output components; SHALL be at least DATA_WIDTH.
REQ-003 SHALL have parameter STRIDE, default 4, butterfly span in samples; SHALL be a power of two and at least 1.
REQ-004 SHALL have parameter ALIGN_DELAY, default 2, cycles by which out0 lags out1, matching the downstream butterfly twiddle latency; SHALL be at least 1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  sample-acceptance enable.
REQ-008 in_valid  input  1  real_in/imag_in carry a sample this cycle.
REQ-009 real_in, imag_in  input  DATA_WIDTH each  signed serial sample.
REQ-010 real_out1, imag_out1  output  VIRTUAL_DATA_WIDTH each  signed later sample x[n+STRIDE], the twiddled butterfly leg.
REQ-011 valid1  output  1  real_out1/imag_out1/pair_index are valid.
REQ-012 pair_index  output  max(1,log2(STRIDE))  n mod STRIDE of the current pair, for twiddle selection.
REQ-013 real_out0, imag_out0  output  VIRTUAL_DATA_WIDTH each  signed earlier sample x[n].
REQ-014 valid0  output  1  real_out0/imag_out0 are valid.

Function
REQ-015 A sample SHALL be accepted at a rising edge only when enable=1 and in_valid=1; otherwise inputs are ignored.
REQ-016 A sample counter SHALL count accepted samples modulo 2*STRIDE, wrapping from 2*STRIDE-1 to 0.
REQ-017 State FILL (counter < STRIDE): each accepted sample SHALL be written, sign-extended, into a STRIDE-deep FIFO; no outputs become valid.
REQ-018 State PAIR (counter >= STRIDE): each accepted sample x[n+STRIDE] SHALL pop the oldest FIFO entry x[n], forming one pair.
REQ-019 FILL SHALL transition to PAIR after the STRIDE-th accepted sample, and PAIR to FILL after the 2*STRIDE-th, with no idle cycle.
REQ-020 A pair accepted at edge k SHALL set real_out1/imag_out1 (sign-extended), valid1=1 and pair_index=counter-STRIDE at edge k.
REQ-021 The popped x[n] SHALL travel through an ALIGN_DELAY-stage register pipe and appear on real_out0/imag_out0 with valid0=1 exactly at edge k+ALIGN_DELAY.
REQ-022 valid1 SHALL be deasserted at any edge with no pair acceptance; the pipe carries the corresponding valid0=0 bubble.
REQ-023 Data outputs SHALL hold their last values while the corresponding valid is 0.
REQ-024 enable=0 SHALL freeze the counter, state and FIFO only; the alignment pipe SHALL keep shifting so in-flight out0 data still emerges on schedule.
REQ-025 Gaps in in_valid SHALL NOT affect pairing: pairing SHALL depend only on accepted-sample order.
REQ-026 Sign extension SHALL replicate bit DATA_WIDTH-1; no saturation, rounding or arithmetic SHALL be applied.
REQ-027 For STRIDE=1, the FIFO SHALL be depth 1, pair_index SHALL be 0, and states SHALL alternate every accepted sample.

Reset
REQ-028 While rst=1, all outputs, the counter, the alignment pipe and FIFO pointers SHALL be 0 and state SHALL be FILL, regardless of clk.
REQ-029 Reset mid-block SHALL discard the partial block and any in-flight pairs; the first sample accepted after release SHALL be treated as x[0].

Verification
REQ-030 Assert rst, then release with no input -> all outputs 0, valid0=valid1=0 indefinitely.
REQ-031 STRIDE=4, 8 contiguous samples real=1..8, imag=-1..-8 -> valid1 high 4 cycles with real_out1=5,6,7,8 and pair_index=0,1,2,3; valid0 high 2 cycles later with real_out0=1,2,3,4 and imag_out0=-1..-4.
REQ-032 Same 8 samples with in_valid low every other cycle -> same pairs, with valid1/valid0 pulses spaced 2 cycles apart and the same 2-cycle out0 lag.
REQ-033 enable=0 for 3 cycles immediately after the 5th sample is accepted -> out0=1 still appears 2 cycles after out1=5; samples 6..8 pair with 2..4 after enable returns.
REQ-034 rst pulse after 6 accepted samples, then 8 new samples 10..17 -> no pending out0 emerges; pairs are (10,14),(11,15),(12,16),(13,17).
REQ-035 Input real_in=16'h8000 (-32768) in the pairing leg -> real_out1=18'h38000.
